// File: rtl/upload_req_arbiter_if.sv
// Request-upload bus between three upload engines, the arbiter and the outgoing
// request FIFO. The arbiter uses the slave modport; the engine/FIFO side uses master.
interface upload_req_arbiter_if #(
    parameter int FLIT_W = 16
);
    logic [2:0]          v_flit_in;
    logic [3*FLIT_W-1:0] flit_in;
    logic [5:0]          ctrl_in;
    logic [2:0]          rdy_out;
    logic                fifo_rdy_in;
    logic                v_flit_out;
    logic [FLIT_W-1:0]   flit_out;
    logic [1:0]          ctrl_out;

    modport master (
        output v_flit_in,
        output flit_in,
        output ctrl_in,
        output fifo_rdy_in,
        input  rdy_out,
        input  v_flit_out,
        input  flit_out,
        input  ctrl_out
    );

    modport slave (
        input  v_flit_in,
        input  flit_in,
        input  ctrl_in,
        input  fifo_rdy_in,
        output rdy_out,
        output v_flit_out,
        output flit_out,
        output ctrl_out
    );
endinterface

// File: rtl/upload_req_arbiter.sv
// Packet-atomic arbiter of three upload engines onto one request FIFO, with flit-count watchdog.
// Define UPLOAD_ARB_RR_EN for round-robin selection; otherwise fixed priority 2 > 1 > 0.
module upload_req_arbiter #(
    parameter int FLIT_W    = 16,
    parameter int MAX_FLITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    upload_req_arbiter_if.slave  bus,
    output logic [1:0]           grant_id,
    output logic [1:0]           fsm_state,
    output logic                 err_len
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01
    } state_t;

    localparam logic [1:0] NO_OWNER  = 2'd3;
    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_TAIL = 2'b11;
    localparam logic [3:0] MAX_CNT   = 4'(MAX_FLITS);

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [3:0]         count_q, count_d;
    logic               err_len_q, err_len_d;

    logic [FLIT_W-1:0]  req_flit [3];
    logic [1:0]         req_ctrl [3];
    logic [2:0]         eligible;
    logic [1:0]         winner;

    logic               own_v;
    logic [FLIT_W-1:0]  own_flit;
    logic [1:0]         own_ctrl;
    logic               xfer;
    logic [3:0]         count_inc;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req
            assign req_flit[gi] = bus.flit_in[gi*FLIT_W +: FLIT_W];
            assign req_ctrl[gi] = bus.ctrl_in[2*gi +: 2];
            assign eligible[gi] = bus.v_flit_in[gi] && (req_ctrl[gi] == CTRL_HEAD);
        end
    endgenerate

    // Owner's lane, forced quiet when nobody owns the FIFO.
    always_comb begin
        own_v    = 1'b0;
        own_flit = '0;
        own_ctrl = 2'b00;
        case (owner_q)
            2'd0: begin
                own_v    = bus.v_flit_in[0];
                own_flit = req_flit[0];
                own_ctrl = req_ctrl[0];
            end
            2'd1: begin
                own_v    = bus.v_flit_in[1];
                own_flit = req_flit[1];
                own_ctrl = req_ctrl[1];
            end
            2'd2: begin
                own_v    = bus.v_flit_in[2];
                own_flit = req_flit[2];
                own_ctrl = req_ctrl[2];
            end
            default: ;
        endcase
    end

`ifdef UPLOAD_ARB_RR_EN
    logic [1:0] last_q, last_d;

    // Search begins just after the last engine to finish a packet.
    always_comb begin
        winner = 2'd0;
        case (last_q)
            2'd0: begin
                if (eligible[1])      winner = 2'd1;
                else if (eligible[2]) winner = 2'd2;
                else                  winner = 2'd0;
            end
            2'd1: begin
                if (eligible[2])      winner = 2'd2;
                else if (eligible[0]) winner = 2'd0;
                else                  winner = 2'd1;
            end
            default: begin
                if (eligible[0])      winner = 2'd0;
                else if (eligible[1]) winner = 2'd1;
                else                  winner = 2'd2;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 2'd2;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        winner = 2'd0;
        if (eligible[2])      winner = 2'd2;
        else if (eligible[1]) winner = 2'd1;
    end
`endif

    assign xfer      = (state_q == BUSY) && own_v && bus.fifo_rdy_in;
    assign count_inc = count_q + 4'd1;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        count_d        = count_q;
        err_len_d      = 1'b0;
`ifdef UPLOAD_ARB_RR_EN
        last_d         = last_q;
`endif
        bus.rdy_out    = 3'b000;
        bus.v_flit_out = 1'b0;
        bus.flit_out   = '0;
        bus.ctrl_out   = 2'b00;

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = BUSY;
                    owner_d = winner;
                    count_d = 4'd0;
                end
            end
            BUSY: begin
                case (owner_q)
                    2'd0:    bus.rdy_out = {2'b00, bus.fifo_rdy_in};
                    2'd1:    bus.rdy_out = {1'b0, bus.fifo_rdy_in, 1'b0};
                    2'd2:    bus.rdy_out = {bus.fifo_rdy_in, 2'b00};
                    default: bus.rdy_out = 3'b000;
                endcase
                bus.v_flit_out = own_v;
                bus.flit_out   = own_flit;
                bus.ctrl_out   = own_ctrl;

                // A stray head mid-packet is just data; only tail or overrun end the grant.
                if (xfer) begin
                    count_d = count_inc;
                    if (own_ctrl == CTRL_TAIL) begin
                        state_d = IDLE;
                        owner_d = NO_OWNER;
`ifdef UPLOAD_ARB_RR_EN
                        last_d  = owner_q;
`endif
                    end else if (count_inc == MAX_CNT) begin
                        state_d   = IDLE;
                        owner_d   = NO_OWNER;
                        err_len_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NO_OWNER;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= NO_OWNER;
            count_q   <= 4'd0;
            err_len_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            count_q   <= count_d;
            err_len_q <= err_len_d;
        end
    end

    assign grant_id  = owner_q;
    assign fsm_state = state_q;
    assign err_len   = err_len_q;

endmodule

// File: tb/tb_upload_req_arbiter.sv
// Directed bench for upload_req_arbiter: single packet, contention, stall, watchdog, async reset.
module tb_upload_req_arbiter;
    localparam int FLIT_W = 16;

`ifdef UPLOAD_ARB_RR_EN
    localparam int EXP_ORDER [4] = '{0, 1, 2, 0};
    localparam int EXP_FIRST      = 0;
`else
    localparam int EXP_ORDER [4] = '{2, 2, 2, 2};
    localparam int EXP_FIRST      = 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic [1:0] fsm_state;
    logic       err_len;
    logic [8:0] status;
    logic [8:0] exp_st;
    logic [17:0] exp_fc;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    upload_req_arbiter_if #(.FLIT_W(FLIT_W)) bus ();

    upload_req_arbiter #(.FLIT_W(FLIT_W), .MAX_FLITS(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .grant_id  (grant_id),
        .fsm_state (fsm_state),
        .err_len   (err_len)
    );

    assign status = {fsm_state, grant_id, bus.rdy_out, bus.v_flit_out, err_len};

    function automatic logic [8:0] st(input logic [1:0] fsm, input logic [1:0] gid,
                                      input logic [2:0] rdy, input logic v, input logic err);
        return {fsm, gid, rdy, v, err};
    endfunction

    function automatic logic [1:0] ctl(input int k, input int n);
        if (k == 0)     return 2'b01;
        if (k == n - 1) return 2'b11;
        return 2'b10;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic [15:0] f, input logic [1:0] c);
        bus.v_flit_in[i]               = v;
        bus.flit_in[i*FLIT_W +: FLIT_W] = f;
        bus.ctrl_in[2*i +: 2]          = c;
    endtask

    task automatic idle_all;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 16'h0000, 2'b00);
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        tick;
        tick;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        bus.fifo_rdy_in = 1'b0;
        idle_all;
        tick;
        exp_st = st(2'd0, 2'd3, 3'b000, 1'b0, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL reset_status: got %h want %h", status, exp_st);
        end
        vectors++;
        if ({bus.flit_out, bus.ctrl_out} !== 18'd0) begin
            miscompares++;
            $display("FAIL reset_flit: got %h want 0", {bus.flit_out, bus.ctrl_out});
        end
        tick;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_single_packet;
        logic [15:0] f [3];
        f = '{16'h1001, 16'h00AB, 16'h00CD};
        bus.fifo_rdy_in = 1'b1;
        drive(1, 1'b1, f[0], 2'b01);
        settle;
        exp_st = st(2'd0, 2'd3, 3'b000, 1'b0, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL single_idle: got %h want %h", status, exp_st);
        end
        vectors++;
        if ({bus.flit_out, bus.ctrl_out} !== 18'd0) begin
            miscompares++;
            $display("FAIL single_idle_flit: got %h want 0", {bus.flit_out, bus.ctrl_out});
        end
        tick;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, f[k], ctl(k, 3));
            settle;
            exp_st = st(2'd1, 2'd1, 3'b010, 1'b1, 1'b0);
            vectors++;
            if (status !== exp_st) begin
                miscompares++;
                $display("FAIL single_busy k=%0d: got %h want %h", k, status, exp_st);
            end
            exp_fc = {f[k], ctl(k, 3)};
            vectors++;
            if ({bus.flit_out, bus.ctrl_out} !== exp_fc) begin
                miscompares++;
                $display("FAIL single_flit k=%0d: got %h want %h", k, {bus.flit_out, bus.ctrl_out}, exp_fc);
            end
            tick;
        end
        drive(1, 1'b0, 16'h0000, 2'b00);
        settle;
        exp_st = st(2'd0, 2'd3, 3'b000, 1'b0, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL single_after_tail: got %h want %h", status, exp_st);
        end
    endtask

    task automatic test_back_to_back;
        int own;
        apply_reset;
        bus.fifo_rdy_in = 1'b1;
        for (int p = 0; p < 4; p++) begin
            own = EXP_ORDER[p];
            for (int i = 0; i < 3; i++) drive(i, 1'b1, 16'((i + 1) * 4096 + p * 16), 2'b01);
            settle;
            exp_st = st(2'd0, 2'd3, 3'b000, 1'b0, 1'b0);
            vectors++;
            if (status !== exp_st) begin
                miscompares++;
                $display("FAIL b2b_gap p=%0d: got %h want %h", p, status, exp_st);
            end
            tick;
            for (int k = 0; k < 3; k++) begin
                drive(own, 1'b1, 16'((own + 1) * 4096 + p * 16 + k), ctl(k, 3));
                settle;
                exp_st = st(2'd1, 2'(own), 3'(3'b001 << own), 1'b1, 1'b0);
                vectors++;
                if (status !== exp_st) begin
                    miscompares++;
                    $display("FAIL b2b_grant p=%0d k=%0d: got %h want %h", p, k, status, exp_st);
                end
                exp_fc = {16'((own + 1) * 4096 + p * 16 + k), ctl(k, 3)};
                vectors++;
                if ({bus.flit_out, bus.ctrl_out} !== exp_fc) begin
                    miscompares++;
                    $display("FAIL b2b_flit p=%0d k=%0d: got %h want %h", p, k, {bus.flit_out, bus.ctrl_out}, exp_fc);
                end
                tick;
            end
        end
        idle_all;
    endtask

    task automatic test_stall;
        bus.fifo_rdy_in = 1'b1;
        drive(0, 1'b1, 16'hC000, 2'b01);
        tick;
        for (int k = 0; k < 9; k++) begin
            if (k == 2) begin
                for (int s = 0; s < 5; s++) begin
                    bus.fifo_rdy_in = 1'b0;
                    drive(0, 1'b1, 16'(16'hC000 + k), ctl(k, 9));
                    settle;
                    exp_st = st(2'd1, 2'd0, 3'b000, 1'b1, 1'b0);
                    vectors++;
                    if (status !== exp_st) begin
                        miscompares++;
                        $display("FAIL stall_hold s=%0d: got %h want %h", s, status, exp_st);
                    end
                    tick;
                end
                bus.fifo_rdy_in = 1'b1;
            end
            drive(0, 1'b1, 16'(16'hC000 + k), ctl(k, 9));
            settle;
            exp_st = st(2'd1, 2'd0, 3'b001, 1'b1, 1'b0);
            vectors++;
            if (status !== exp_st) begin
                miscompares++;
                $display("FAIL stall_xfer k=%0d: got %h want %h", k, status, exp_st);
            end
            exp_fc = {16'(16'hC000 + k), ctl(k, 9)};
            vectors++;
            if ({bus.flit_out, bus.ctrl_out} !== exp_fc) begin
                miscompares++;
                $display("FAIL stall_flit k=%0d: got %h want %h", k, {bus.flit_out, bus.ctrl_out}, exp_fc);
            end
            tick;
        end
        idle_all;
        settle;
        exp_st = st(2'd0, 2'd3, 3'b000, 1'b0, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL stall_end: got %h want %h", status, exp_st);
        end
        tick;
    endtask

    task automatic test_overrun;
        bus.fifo_rdy_in = 1'b1;
        drive(0, 1'b1, 16'hE000, 2'b01);
        tick;
        for (int k = 0; k < 11; k++) begin
            drive(0, 1'b1, 16'(16'hE000 + k), (k == 0) ? 2'b01 : 2'b10);
            settle;
            exp_st = st(2'd1, 2'd0, 3'b001, 1'b1, 1'b0);
            vectors++;
            if (status !== exp_st) begin
                miscompares++;
                $display("FAIL ovr_fwd k=%0d: got %h want %h", k, status, exp_st);
            end
            exp_fc = {16'(16'hE000 + k), (k == 0) ? 2'b01 : 2'b10};
            vectors++;
            if ({bus.flit_out, bus.ctrl_out} !== exp_fc) begin
                miscompares++;
                $display("FAIL ovr_flit k=%0d: got %h want %h", k, {bus.flit_out, bus.ctrl_out}, exp_fc);
            end
            tick;
        end
        drive(0, 1'b1, 16'hE00B, 2'b10);
        settle;
        exp_st = st(2'd0, 2'd3, 3'b000, 1'b0, 1'b1);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL ovr_release: got %h want %h", status, exp_st);
        end
        tick;
        settle;
        exp_st = st(2'd0, 2'd3, 3'b000, 1'b0, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL ovr_no_regrant: got %h want %h", status, exp_st);
        end
        tick;
        drive(0, 1'b1, 16'hE00B, 2'b01);
        tick;
        settle;
        exp_st = st(2'd1, 2'd0, 3'b001, 1'b1, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL ovr_regrant: got %h want %h", status, exp_st);
        end
        tick;
        drive(0, 1'b1, 16'hE00C, 2'b11);
        tick;
        idle_all;
        settle;
        exp_st = st(2'd0, 2'd3, 3'b000, 1'b0, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL ovr_end: got %h want %h", status, exp_st);
        end
        tick;
    endtask

    task automatic test_reset_mid_packet;
        bus.fifo_rdy_in = 1'b1;
        drive(2, 1'b1, 16'hB000, 2'b01);
        tick;
        for (int k = 0; k < 2; k++) begin
            drive(2, 1'b1, 16'(16'hB000 + k), ctl(k, 4));
            tick;
        end
        drive(2, 1'b1, 16'hB002, 2'b10);
        settle;
        exp_st = st(2'd1, 2'd2, 3'b100, 1'b1, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL rstmid_busy: got %h want %h", status, exp_st);
        end
        rst = 1'b0;
        #1;
        exp_st = st(2'd0, 2'd3, 3'b000, 1'b0, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL rstmid_async: got %h want %h", status, exp_st);
        end
        vectors++;
        if ({bus.flit_out, bus.ctrl_out} !== 18'd0) begin
            miscompares++;
            $display("FAIL rstmid_flit: got %h want 0", {bus.flit_out, bus.ctrl_out});
        end
        tick;
        rst = 1'b1;
        drive(0, 1'b1, 16'h0A01, 2'b01);
        drive(2, 1'b1, 16'h2A01, 2'b01);
        tick;
        settle;
        exp_st = st(2'd1, 2'(EXP_FIRST), 3'(3'b001 << EXP_FIRST), 1'b1, 1'b0);
        vectors++;
        if (status !== exp_st) begin
            miscompares++;
            $display("FAIL rstmid_winner: got %h want %h", status, exp_st);
        end
        idle_all;
        apply_reset;
    endtask

    initial begin
        bus.v_flit_in   = 3'b000;
        bus.flit_in     = '0;
        bus.ctrl_in     = 6'b000000;
        bus.fifo_rdy_in = 1'b0;
        test_reset;
        test_single_packet;
        test_back_to_back;
        test_stall;
        test_overrun;
        test_reset_mid_packet;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
